// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package seg_scan_pkg;

  // Scan phase: all digits dark, or one digit lit.
  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // Width of one digit code as seen by the BCD-to-7-segment decoder.
  localparam int CODE_W = 4;

  // Nibble presented to the decoder while no digit is lit.
  localparam logic [CODE_W-1:0] BLANK_NIBBLE = 4'h0;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Host-write and display-drive signals of the scan controller.
interface seg_scan_ctrl_if
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int IDX_W      = $clog2(NUM_DIGITS)
);

  logic                  en;
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_addr;
  logic [CODE_W-1:0]     wr_data;
  logic                  wr_dp;
  logic                  commit;
  logic                  a;
  logic                  b;
  logic                  c;
  logic                  d;
  logic                  dp;
  logic [NUM_DIGITS-1:0] digit_en;
  logic                  pending;
  logic                  frame_done;

  // Host side: drives writes/commit/enable, observes the display pins.
  modport master (
    output en, wr_en, wr_addr, wr_data, wr_dp, commit,
    input  a, b, c, d, dp, digit_en, pending, frame_done
  );

  // Controller side.
  modport slave (
    input  en, wr_en, wr_addr, wr_data, wr_dp, commit,
    output a, b, c, d, dp, digit_en, pending, frame_done
  );

endinterface

// File: rtl/seg_scan_timer.sv
// Scan sequencer: alternates BLANK gaps and SHOW windows across digit
// positions and flags the transitions the top level reacts to.
module seg_scan_timer
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int BLANK_CYC  = 16,
  parameter int IDX_W      = $clog2(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [IDX_W-1:0] idx,
  output logic             show_start,
  output logic             show_end,
  output logic             frame_end
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO   = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_t      state;
  scan_state_t      state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [IDX_W-1:0] idx_next;

  // Sequencer registers; disabling the scan parks it at the start of digit 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= BLANK;
      cnt   <= CNT_ZERO;
      idx   <= IDX_ZERO;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
    end
  end

  // Next-state decode plus one-cycle transition flags for the coming edge.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    show_start = 1'b0;
    show_end   = 1'b0;
    frame_end  = 1'b0;
    if (!en) begin
      state_next = BLANK;
      cnt_next   = CNT_ZERO;
      idx_next   = IDX_ZERO;
    end else begin
      case (state)
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_next = SHOW;
            cnt_next   = CNT_ZERO;
            show_start = 1'b1;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            state_next = BLANK;
            cnt_next   = CNT_ZERO;
            show_end   = 1'b1;
            if (idx == IDX_LAST) begin
              idx_next  = IDX_ZERO;
              frame_end = 1'b1;
            end else begin
              idx_next = idx + IDX_ONE;
            end
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
        default: begin
          state_next = BLANK;
          cnt_next   = CNT_ZERO;
          idx_next   = IDX_ZERO;
        end
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a tear-free double-buffered
// digit store. Shadow writes become visible only at a frame boundary (or at
// once while the display is dark).
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int BLANK_CYC  = 16,
  parameter int IDX_W      = $clog2(NUM_DIGITS)
) (
  input logic            clk,
  input logic            rst_n,
  seg_scan_ctrl_if.slave bus
);

  logic [CODE_W-1:0]     shadow_code [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] shadow_dp;
  logic [CODE_W-1:0]     disp_code   [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] disp_dp;

  logic [IDX_W-1:0] idx;
  logic             show_start;
  logic             show_end;
  logic             frame_end;
  logic             copy;
  logic             addr_ok;

  seg_scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV),
    .BLANK_CYC  (BLANK_CYC),
    .IDX_W      (IDX_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (bus.en),
    .idx        (idx),
    .show_start (show_start),
    .show_end   (show_end),
    .frame_end  (frame_end)
  );

  // One-hot digit select for position i.
  function automatic logic [NUM_DIGITS-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NUM_DIGITS-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Copy decision uses the registered pending flag, so a commit arriving on
  // the boundary cycle waits for the next boundary.
  always_comb begin
    copy    = 1'b0;
    addr_ok = 1'b0;
    if (bus.pending && (frame_end || !bus.en)) begin
      copy = 1'b1;
    end else begin
      copy = 1'b0;
    end
    if ({1'b0, bus.wr_addr} < (IDX_W + 1)'(NUM_DIGITS)) begin
      addr_ok = 1'b1;
    end else begin
      addr_ok = 1'b0;
    end
  end

  // Shadow bank: host writes land here at any time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_code[i] <= BLANK_NIBBLE;
      end
      shadow_dp <= '0;
    end else if (bus.wr_en && addr_ok) begin
      shadow_code[bus.wr_addr] <= bus.wr_data;
      shadow_dp[bus.wr_addr]   <= bus.wr_dp;
    end
  end

  // Display bank: snapshot of the shadow bank taken before same-cycle writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        disp_code[i] <= BLANK_NIBBLE;
      end
      disp_dp <= '0;
    end else if (copy) begin
      disp_code <= shadow_code;
      disp_dp   <= shadow_dp;
    end
  end

  // Commit tracking: extra commits while pending are absorbed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.pending    <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.pending    <= bus.commit | (bus.pending & ~copy);
      bus.frame_done <= copy;
    end
  end

  // Digit drive: nibble, dp and enable change together so the shown value is
  // stable for the whole SHOW window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {bus.a, bus.b, bus.c, bus.d} <= BLANK_NIBBLE;
      bus.dp                       <= 1'b0;
      bus.digit_en                 <= '0;
    end else if (!bus.en || show_end) begin
      {bus.a, bus.b, bus.c, bus.d} <= BLANK_NIBBLE;
      bus.dp                       <= 1'b0;
      bus.digit_en                 <= '0;
    end else if (show_start) begin
      {bus.a, bus.b, bus.c, bus.d} <= disp_code[idx];
      bus.dp                       <= disp_dp[idx];
      bus.digit_en                 <= onehot(idx);
    end
  end

endmodule
